// File: rtl/ads_touch_ctrl_if.sv
// Avalon-MM slave port bundle for the ADS7843 touch-controller block.
// The master modport is the bus side; the slave modport is the peripheral.
interface ads_touch_ctrl_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic        read_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address, chipselect, write_n, read_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write_n, read_n, writedata,
      output readdata
   );
endinterface

// File: rtl/ads_touch_ctrl.sv
// Runs one ADS7843-style conversion per CMD write: drives CS/DCLK/DIN, captures the 12-bit result from DOUT,
// and reports completion through STATUS and a level interrupt.
module ads_touch_ctrl #(
   parameter logic [7:0] DEFAULT_DIV = 8'd24
) (
   input  logic            clk,
   input  logic            reset_n,
   ads_touch_ctrl_if.slave bus,
   output logic            ads_cs_n,
   output logic            ads_clk,
   output logic            ads_din,
   input  logic            ads_dout,
   input  logic            ads_penirq_n,
   output logic            irq
);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

   state_t      state, state_d;
   logic [7:0]  hcnt, hcnt_d;
   logic [4:0]  bitcnt, bitcnt_d;
   logic        phase, phase_d;
   logic        cs_n_d, clk_d, din_d;
   logic        sample, finish;

   logic [7:0]  cmd, clkdiv, div_lat, cmd_src;
   logic [11:0] shreg, data;
   logic        busy, done, done_d, irq_en, irq_en_d;
   logic        pen_meta, pen_sync;
   logic        wr, rd_data, start, tc;
   logic        unused_wdata;

   assign wr           = bus.chipselect & ~bus.write_n;
   assign rd_data      = bus.chipselect & ~bus.read_n & (bus.address == 2'd2);
   assign start        = wr & (bus.address == 2'd0) & ~busy;
   assign tc           = (hcnt == div_lat);
   assign cmd_src      = start ? bus.writedata[7:0] : cmd;
   assign unused_wdata = ^bus.writedata[31:8];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         hcnt     <= 8'd0;
         bitcnt   <= 5'd0;
         phase    <= 1'b0;
         ads_cs_n <= 1'b1;
         ads_clk  <= 1'b0;
         ads_din  <= 1'b0;
      end else begin
         state    <= state_d;
         hcnt     <= hcnt_d;
         bitcnt   <= bitcnt_d;
         phase    <= phase_d;
         ads_cs_n <= cs_n_d;
         ads_clk  <= clk_d;
         ads_din  <= din_d;
      end
   end

   // Pins are registered from the next-state values so DCLK/CS/DIN are glitch-free and DIN only moves
   // on the edge where DCLK falls or SETUP begins.
   always_comb begin
      state_d  = state;
      hcnt_d   = hcnt;
      bitcnt_d = bitcnt;
      phase_d  = phase;
      sample   = 1'b0;
      finish   = 1'b0;
      case (state)
         IDLE: begin
            hcnt_d = 8'd0;
            if (start) state_d = SETUP;
         end
         SETUP: begin
            if (tc) begin
               state_d  = SHIFT;
               hcnt_d   = 8'd0;
               phase_d  = 1'b0;
               bitcnt_d = 5'd0;
            end else begin
               hcnt_d = hcnt + 8'd1;
            end
         end
         SHIFT: begin
            if (!tc) begin
               hcnt_d = hcnt + 8'd1;
            end else begin
               hcnt_d = 8'd0;
               if (!phase) begin
                  phase_d = 1'b1;
                  sample  = (bitcnt >= 5'd9) && (bitcnt <= 5'd20);
               end else begin
                  phase_d = 1'b0;
                  if (bitcnt == 5'd23) state_d = HOLD;
                  else bitcnt_d = bitcnt + 5'd1;
               end
            end
         end
         HOLD: begin
            if (tc) begin
               state_d = DONE;
               hcnt_d  = 8'd0;
            end else begin
               hcnt_d = hcnt + 8'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
            finish  = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      cs_n_d = (state_d == IDLE) || (state_d == DONE);
      clk_d  = (state_d == SHIFT) && phase_d;
      din_d  = 1'b0;
      if (state_d == SETUP)
         din_d = cmd_src[7];
      else if ((state_d == SHIFT) && (bitcnt_d < 5'd8))
         din_d = cmd_src[3'd7 - bitcnt_d[2:0]];
   end

   // A DATA read landing in the DONE cycle must not lose the completion flag, so set beats clear.
   always_comb begin
      done_d = done;
      if (start || rd_data) done_d = 1'b0;
      if (finish) done_d = 1'b1;
      irq_en_d = (wr && (bus.address == 2'd1)) ? bus.writedata[3] : irq_en;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cmd     <= 8'd0;
         clkdiv  <= DEFAULT_DIV;
         div_lat <= DEFAULT_DIV;
         shreg   <= 12'd0;
         data    <= 12'd0;
         busy    <= 1'b0;
         done    <= 1'b0;
         irq_en  <= 1'b0;
         irq     <= 1'b0;
      end else begin
         if (wr && (bus.address == 2'd3)) clkdiv <= bus.writedata[7:0];
         if (start) begin
            cmd     <= bus.writedata[7:0];
            div_lat <= clkdiv;
            busy    <= 1'b1;
         end
         if (sample) shreg <= {shreg[10:0], ads_dout};
         if (finish) begin
            busy <= 1'b0;
            data <= shreg;
         end
         done   <= done_d;
         irq_en <= irq_en_d;
         irq    <= done_d & irq_en_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pen_meta <= 1'b1;
         pen_sync <= 1'b1;
      end else begin
         pen_meta <= ads_penirq_n;
         pen_sync <= pen_meta;
      end
   end

   always_comb begin
      bus.readdata = 32'd0;
      case (bus.address)
         2'd0:    bus.readdata = {24'd0, cmd};
         2'd1:    bus.readdata = {28'd0, irq_en, ~pen_sync, done, busy};
         2'd2:    bus.readdata = {20'd0, data};
         default: bus.readdata = {24'd0, clkdiv};
      endcase
   end

endmodule

// File: tb/tb_ads_touch_ctrl.sv
// Bench for ads_touch_ctrl: random conversions checked against a transaction-level model of the
// touch controller, plus reset, interrupt, busy-lockout and pen-synchroniser scenarios.
module tb_ads_touch_ctrl;

   logic clk = 1'b0;
   logic reset_n;
   logic ads_cs_n, ads_clk, ads_din, irq;
   logic ads_dout = 1'b0;
   logic ads_penirq_n;

   ads_touch_ctrl_if bus ();

   ads_touch_ctrl #(.DEFAULT_DIV(8'd24)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .bus          (bus),
      .ads_cs_n     (ads_cs_n),
      .ads_clk      (ads_clk),
      .ads_din      (ads_din),
      .ads_dout     (ads_dout),
      .ads_penirq_n (ads_penirq_n),
      .irq          (irq)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // Model of the touch controller: logs DCLK edges and DIN, and presents the chosen result on DOUT
   // so that period p (9..20) carries result[20-p].
   int          rise_cyc[$];
   int          fall_cyc[$];
   bit          din_log[$];
   logic        prev_clk = 1'b0;
   logic [11:0] model_result = 12'd0;

   always @(negedge clk) begin
      if (ads_clk && !prev_clk) begin
         rise_cyc.push_back(cyc);
         din_log.push_back(ads_din);
         if (rise_cyc.size() >= 9 && rise_cyc.size() <= 20)
            ads_dout = model_result[20 - rise_cyc.size()];
         else
            ads_dout = 1'($urandom_range(1));
      end
      if (!ads_clk && prev_clk) fall_cyc.push_back(cyc);
      prev_clk = ads_clk;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic bus_idle();
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus.read_n     = 1'b1;
      bus.address    = 2'd0;
      bus.writedata  = 32'd0;
   endtask

   task automatic bus_write(input logic [1:0] addr, input logic [31:0] wdata);
      @(negedge clk);
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      bus.read_n     = 1'b1;
      bus.address    = addr;
      bus.writedata  = wdata;
      @(negedge clk);
      bus_idle();
   endtask

   task automatic bus_read(input logic [1:0] addr, output logic [31:0] rdata);
      @(negedge clk);
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b1;
      bus.read_n     = 1'b0;
      bus.address    = addr;
      #1 rdata = bus.readdata;
      @(posedge clk);
      #1 bus_idle();
   endtask

   // One full conversion: optional CMD write during busy, optional DATA read in the DONE cycle.
   task automatic applyStimulus(input logic [7:0] cmd, input logic [7:0] div, input bit irq_on,
                                input bit lockout, input bit read_in_done);
      int          exp_len, start_cyc, busy_len, off;
      logic [31:0] rd;
      logic [23:0] din_vec;
      exp_len  = 2 + 50 * (int'(div) + 1);
      busy_len = -1;
      model_result = 12'($urandom);
      bus_write(2'd1, {28'd0, irq_on, 3'b000});
      bus_write(2'd3, {24'($urandom), div});
      rise_cyc.delete();
      fall_cyc.delete();
      din_log.delete();

      @(negedge clk);
      start_cyc      = cyc;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      bus.read_n     = 1'b1;
      bus.address    = 2'd0;
      bus.writedata  = {24'($urandom), cmd};
      @(negedge clk);
      checkOutput("cs_n_fall", ads_cs_n, 1'b0);

      for (int i = 0; i < exp_len + 64; i++) begin
         off            = cyc - start_cyc;
         bus.chipselect = 1'b1;
         bus.write_n    = 1'b1;
         bus.read_n     = 1'b0;
         bus.address    = 2'd1;
         if (lockout && off == 10) begin
            bus.read_n    = 1'b1;
            bus.write_n   = 1'b0;
            bus.address   = 2'd0;
            bus.writedata = 32'hD3;
         end else if (read_in_done && off == exp_len - 1) begin
            bus.address = 2'd2;
         end else begin
            #1;
            if (bus.readdata[0] == 1'b0) begin
               busy_len = off;
               break;
            end
         end
         @(negedge clk);
      end
      bus_idle();

      checkOutput("busy_len", busy_len, exp_len);
      checkOutput("irq_at_done", irq, irq_on);
      checkOutput("rise_count", rise_cyc.size(), 24);
      din_vec = 24'd0;
      for (int k = 0; k < din_log.size() && k < 24; k++) din_vec[23-k] = din_log[k];
      checkOutput("din_seq", din_vec, {cmd, 16'd0});
      if (rise_cyc.size() >= 2 && fall_cyc.size() >= 1) begin
         checkOutput("dclk_high_len", fall_cyc[0] - rise_cyc[0], int'(div) + 1);
         checkOutput("dclk_low_len", rise_cyc[1] - fall_cyc[0], int'(div) + 1);
      end

      bus_read(2'd1, rd);
      checkOutput("status_done", rd[3:0], {irq_on, 1'b0, 1'b1, 1'b0});
      bus_read(2'd0, rd);
      checkOutput("cmd_readback", rd, {24'd0, cmd});
      bus_read(2'd2, rd);
      checkOutput("data_result", rd, {20'd0, model_result});
      bus_read(2'd1, rd);
      checkOutput("done_cleared", rd[1], 1'b0);
      checkOutput("irq_cleared", irq, 1'b0);
   endtask

   initial begin
      logic [31:0] rd;
      int          n;
      bus_idle();
      ads_penirq_n = 1'b1;
      reset_n      = 1'b0;
      repeat (3) @(negedge clk);

      checkOutput("rst_cs_n", ads_cs_n, 1'b1);
      checkOutput("rst_clk", ads_clk, 1'b0);
      checkOutput("rst_din", ads_din, 1'b0);
      checkOutput("rst_irq", irq, 1'b0);
      bus_read(2'd1, rd); checkOutput("rst_status", rd, 32'd0);
      bus_read(2'd2, rd); checkOutput("rst_data", rd, 32'd0);
      bus_read(2'd0, rd); checkOutput("rst_cmd", rd, 32'd0);
      bus_read(2'd3, rd); checkOutput("rst_clkdiv", rd, 32'd24);
      @(negedge clk);
      reset_n = 1'b1;

      $display("[TB] basic conversion with busy lockout");
      applyStimulus(8'h93, 8'd0, 1'b0, 1'b1, 1'b0);
      applyStimulus(8'hD3, 8'd0, 1'b0, 1'b0, 1'b0);
      $display("[TB] divider 24");
      applyStimulus(8'h90, 8'd24, 1'b0, 1'b0, 1'b0);
      $display("[TB] interrupt and done clearing");
      applyStimulus(8'($urandom), 8'($urandom_range(3)), 1'b1, 1'b0, 1'b0);
      applyStimulus(8'($urandom), 8'($urandom_range(3)), 1'b1, 1'b0, 1'b1);
      $display("[TB] random conversions");
      for (int r = 0; r < 4; r++)
         applyStimulus(8'($urandom), 8'($urandom_range(3)), 1'($urandom_range(1)), 1'b0,
                       1'($urandom_range(1)));

      $display("[TB] reset mid-transfer");
      bus_write(2'd3, 32'd2);
      rise_cyc.delete();
      fall_cyc.delete();
      din_log.delete();
      bus_write(2'd0, 32'h000000B7);
      for (int i = 0; i < 2000 && rise_cyc.size() < 13; i++) @(negedge clk);
      checkOutput("mid_rises", rise_cyc.size(), 13);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("mid_rst_cs_n", ads_cs_n, 1'b1);
      checkOutput("mid_rst_clk", ads_clk, 1'b0);
      checkOutput("mid_rst_irq", irq, 1'b0);
      bus_read(2'd1, rd); checkOutput("mid_rst_status", rd, 32'd0);
      bus_read(2'd2, rd); checkOutput("mid_rst_data", rd, 32'd0);
      bus_read(2'd3, rd); checkOutput("mid_rst_clkdiv", rd, 32'd24);
      @(negedge clk);
      reset_n = 1'b1;

      $display("[TB] pen synchroniser");
      for (int t = 0; t < 4; t++) begin
         @(negedge clk);
         #3 ads_penirq_n = ~ads_penirq_n;
         bus.chipselect = 1'b1;
         bus.read_n     = 1'b0;
         bus.address    = 2'd1;
         n = 0;
         for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            #1;
            if (bus.readdata[2] == ~ads_penirq_n) begin
               n = k;
               break;
            end
         end
         checkOutput("pen_latency_ok", (n >= 2 && n <= 3), 1'b1);
         checkOutput("pen_busy", bus.readdata[0], 1'b0);
         bus_idle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ads_touch_ctrl.md
# ads_touch_ctrl

Avalon-MM slave that runs complete ADS7843-style touch-controller conversions in hardware, replacing the bit-banged PIO clock/chip-select/data pins used by the TFT+SD design. Software writes an 8-bit control byte. The block then generates chip-select, DCLK and DIN, captures the 12-bit result from DOUT, and reports completion through a status register. It sits on the system Avalon bus alongside the other PIO peripherals.

## Interface
- `DEFAULT_DIV`, 24: reset value of the CLKDIV register. DCLK period is 2·(CLKDIV+1) clk cycles, so 1 MHz at 50 MHz.
- `clk` in 1: system clock; all logic is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `address` in 2: register select. 0 = CMD, 1 = STATUS, 2 = DATA, 3 = CLKDIV.
- `chipselect` in 1: Avalon slave select.
- `write_n` in 1: active-low write strobe.
- `read_n` in 1: active-low read strobe. Used only for read side effects.
- `writedata` in 32: write data.
- `readdata` out 32: read data, combinational from `address`, zero wait states.
- `ads_cs_n` out 1: touch-controller chip select.
- `ads_clk` out 1: DCLK.
- `ads_din` out 1: serial command to the controller.
- `ads_dout` in 1: serial result from the controller.
- `ads_penirq_n` in 1: pen interrupt, asynchronous.
- `irq` out 1: level interrupt, `done & irq_en`.

## Operation
- **Registers.**
  - CMD (write): bits [7:0] are the control byte. Reads return the last byte written.
  - STATUS (read):
    - bit0 `busy`.
    - bit1 `done`.
    - bit2 `pen_down`: inverted `ads_penirq_n` after a 2-flop synchroniser.
    - bit3 `irq_en`, which is also writable through STATUS bit3.
  - DATA (read): bits [11:0] hold the result, other bits are 0. A read with `chipselect & ~read_n & address==2` clears `done`.
  - CLKDIV (read/write): bits [7:0].
- **Starting a conversion.** A CMD write while `busy=0` does the following:
  - latches the control byte and CLKDIV;
  - clears `done`;
  - sets `busy`;
  - moves the FSM IDLE→SETUP.
- A CMD write while `busy=1` is ignored entirely; CMD, data and state are unchanged.
- A CLKDIV write during a transaction takes effect at the next start.
- **FSM states.**
  - IDLE: `ads_cs_n=1`, `ads_clk=0`.
  - SETUP: `ads_cs_n=0`, DIN = cmd[7]. Lasts one half-period.
  - SHIFT: 24 DCLK periods, tracked by a bit counter running 0..23. Each period is low half then high half.
  - HOLD: `ads_clk=0`, `ads_cs_n=0` for one half-period.
  - DONE: one cycle. `ads_cs_n=1`, `busy` clears, `done` sets, DATA updates. Then return to IDLE.
- **Half-period counter.** Counts 0..CLKDIV. Its terminal count advances the DCLK phase.
- **DIN.** Bit i of the command (i = 0..7, MSB first, i.e. cmd[7-i]) is driven during the low half of period i. DIN is 0 for periods 8..23.
- **DOUT capture.** `ads_dout` is sampled in the clk cycle that DCLK rises in periods 9..20. Period 9 gives result[11] and period 20 gives result[0], shifted MSB first.
  - The shift register is internal. DATA is updated only in DONE.
  - Periods 21..23 are fill clocks and are ignored.
- **Reset values.** All outputs and registers return to these whenever `reset_n` is low, including mid-transaction, which aborts immediately:
  - `ads_cs_n=1`, `ads_clk=0`, `ads_din=0`, `irq=0`;
  - `busy=0`, `done=0`, `irq_en=0`;
  - DATA=0, CMD=0, CLKDIV=DEFAULT_DIV.
- **Simultaneous events.** If a DATA read coincides with the DONE cycle, `done` ends set; set wins.

## Timing
- Cycles from the start write to `ads_cs_n` falling: 1 (the FSM enters SETUP on the next edge).
- Total transaction from the start write to `busy` clear is 1 + (D+1)·(1 + 48 + 1) + 1 clk cycles, with D = CLKDIV:
  - 1 cycle: start write to SETUP entry.
  - (D+1) cycles: SETUP half-period.
  - 48·(D+1) cycles: SHIFT.
  - (D+1) cycles: HOLD.
  - 1 cycle: DONE.
- With D=0 this is 52 cycles; with D=24 it is 1252 cycles.
- Minimum CLKDIV is 0, giving DCLK = clk/2. CLKDIV=255 gives the maximum period of 512 cycles.
- DIN changes only on the clk edge at which DCLK falls or SETUP begins. It is stable for the whole high half.
- `irq` and `done` rise in the same cycle; `irq` is registered.
- `pen_down` lags the pin by 2–3 cycles and is independent of the FSM.

## Test plan
- **Basic conversion.** Reset, then write CLKDIV=0 and CMD=0x93. The bench model drives DOUT=0xA5C on periods 9..20.
  - DIN shows 1,0,0,1,0,0,1,1.
  - Exactly 24 DCLK rising edges occur.
  - `busy` clears at cycle 52; DATA=0xA5C; `done=1`.
- **Busy lockout.** During the basic conversion, write CMD=0xD3 at cycle 10.
  - CMD readback stays 0x93 and the DIN sequence is unchanged.
  - A subsequent write after `done` starts a 0xD3 transfer.
- **Divider.** CLKDIV=24 and CMD=0x90: DCLK high and low phases are 25 cycles each, and `busy` lasts 1252 cycles.
- **Interrupt/done clearing.**
  - Set irq_en (STATUS=0x8), run a conversion: `irq` rises with `done`.
  - A DATA read drops both `done` and `irq` the next cycle.
  - A DATA read in the DONE cycle leaves `done=1`.
- **Reset mid-transfer.** Assert `reset_n` low at bit 12. In the same cycle, asynchronously: `ads_cs_n=1`, `ads_clk=0`, STATUS=0, DATA=0, CLKDIV=24.
- **Pen sync.** Toggle `ads_penirq_n` asynchronously: STATUS bit2 follows the inverted pin within 3 cycles, with no effect on `busy`.
